// File: rtl/clk_rst_pkg.sv
// Shared clock/reset definitions: reset-sequencer state encodings and default
// phase lengths used by the PLL reset sequencer and later CDC blocks.
package clk_rst_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_FILTER    = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RUN       = 3'd3
    } seq_state_e;

    localparam int DEF_LOCK_FILTER_CYCLES = 16;
    localparam int DEF_RESET_HOLD_CYCLES  = 64;

    // True when value is representable in an unsigned field of the given width.
    function automatic bit fits_width(input longint unsigned value, input int unsigned width);
        return (width >= 64) || ((value >> width) == 64'd0);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous active-high reset.
// Flops power up at their reset value so the output is defined before reset runs.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q = 1'b0;
    logic sync_q = 1'b0;
    logic meta_d;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: filters the synchronised lock indication, holds the
// processor in reset for a fixed interval, and counts lock losses seen in RUN.
module pll_reset_seq
    import clk_rst_pkg::*;
#(
    parameter int LOCK_FILTER_CYCLES = DEF_LOCK_FILTER_CYCLES,
    parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
    parameter int CNT_WIDTH          = 8,
    parameter int LOSS_CNT_WIDTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pll_lock,
    input  logic                      sw_reset_req,
    output logic                      sys_reset,
    output logic                      ready,
    output logic [2:0]                state,
    output logic                      lock_lost,
    output logic [LOSS_CNT_WIDTH-1:0] loss_count
);

    localparam int MAX_PHASE = (LOCK_FILTER_CYCLES > RESET_HOLD_CYCLES) ?
                               LOCK_FILTER_CYCLES : RESET_HOLD_CYCLES;

    generate
        if (LOCK_FILTER_CYCLES < 1) begin : g_bad_filter
            $error("pll_reset_seq: LOCK_FILTER_CYCLES must be >= 1");
        end
        if (RESET_HOLD_CYCLES < 1) begin : g_bad_hold
            $error("pll_reset_seq: RESET_HOLD_CYCLES must be >= 1");
        end
        if (CNT_WIDTH < 1 || !fits_width(longint'(MAX_PHASE - 1), CNT_WIDTH)) begin : g_bad_cnt
            $error("pll_reset_seq: CNT_WIDTH too small for the longest phase");
        end
        if (LOSS_CNT_WIDTH < 1) begin : g_bad_loss
            $error("pll_reset_seq: LOSS_CNT_WIDTH must be >= 1");
        end
    endgenerate

    localparam logic [CNT_WIDTH-1:0] FILTER_LAST = CNT_WIDTH'(LOCK_FILTER_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);

    function automatic logic [LOSS_CNT_WIDTH-1:0] sat_inc(input logic [LOSS_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + LOSS_CNT_WIDTH'(1);
    endfunction

    logic lock_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // Power-up values match reset values: clk may not toggle until the PLL locks.
    seq_state_e                state_q      = ST_WAIT_LOCK;
    logic [CNT_WIDTH-1:0]      cnt_q        = '0;
    logic                      sys_reset_q  = 1'b1;
    logic                      ready_q      = 1'b0;
    logic                      lock_lost_q  = 1'b0;
    logic [LOSS_CNT_WIDTH-1:0] loss_count_q = '0;

    seq_state_e                state_d;
    logic [CNT_WIDTH-1:0]      cnt_d;
    logic                      sys_reset_d;
    logic                      ready_d;
    logic                      lock_lost_d;
    logic [LOSS_CNT_WIDTH-1:0] loss_count_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lock_lost_d  = 1'b0;
        loss_count_d = loss_count_q;

        case (state_q)
            ST_WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) begin
                    state_d = ST_FILTER;
                end
            end
            ST_FILTER: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == FILTER_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_HOLD: begin
                // A drop during hold restarts the sequence but is not a loss event.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d      = ST_WAIT_LOCK;
                    cnt_d        = '0;
                    lock_lost_d  = 1'b1;
                    loss_count_d = sat_inc(loss_count_q);
                end else if (sw_reset_req) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        // Outputs follow the next state so they switch on the same edge as state.
        ready_d     = (state_d == ST_RUN);
        sys_reset_d = !ready_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_WAIT_LOCK;
            cnt_q        <= '0;
            sys_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
            loss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sys_reset_q  <= sys_reset_d;
            ready_q      <= ready_d;
            lock_lost_q  <= lock_lost_d;
            loss_count_q <= loss_count_d;
        end
    end

    assign sys_reset  = sys_reset_q;
    assign ready      = ready_q;
    assign state      = state_q;
    assign lock_lost  = lock_lost_q;
    assign loss_count = loss_count_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: stimulus queues expected output snapshots
// tagged with the edge they belong to; the monitor compares them on the falling edge.
module tb_pll_reset_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       sw_reset_req;
    logic       sys_reset;
    logic       ready;
    logic [2:0] state;
    logic       lock_lost;
    logic [3:0] loss_count;

    pll_reset_seq #(
        .LOCK_FILTER_CYCLES (16),
        .RESET_HOLD_CYCLES  (64),
        .CNT_WIDTH          (8),
        .LOSS_CNT_WIDTH     (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pll_lock     (pll_lock),
        .sw_reset_req (sw_reset_req),
        .sys_reset    (sys_reset),
        .ready        (ready),
        .state        (state),
        .lock_lost    (lock_lost),
        .loss_count   (loss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at_cyc;
        string      name;
        logic [2:0] st;
        logic       sr;
        logic       rdy;
        logic       ll;
        logic [3:0] lc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   e0     = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Edge k relative to e0 is observed at the falling edge where cyc == e0 + k.
    task automatic exp_at(input int k, input string nm, input logic [2:0] st,
                          input logic sr, input logic rdy, input logic ll, input logic [3:0] lc);
        exp_t e;
        e.at_cyc = e0 + k;
        e.name   = nm;
        e.st     = st;
        e.sr     = sr;
        e.rdy    = rdy;
        e.ll     = ll;
        e.lc     = lc;
        sb.push_back(e);
    endtask

    task automatic wait_to(input int k);
        do @(negedge clk); while (cyc < e0 + k);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].at_cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.at_cyc < cyc) begin
                errors++;
                $display("FAIL %s: sample for cycle %0d missed (now %0d)", e.name, e.at_cyc, cyc);
            end else if ({state, sys_reset, ready, lock_lost, loss_count} !==
                         {e.st, e.sr, e.rdy, e.ll, e.lc}) begin
                errors++;
                $display("FAIL %s: got state=%0d sys_reset=%b ready=%b lock_lost=%b loss_count=%0d, want state=%0d sys_reset=%b ready=%b lock_lost=%b loss_count=%0d",
                         e.name, state, sys_reset, ready, lock_lost, loss_count,
                         e.st, e.sr, e.rdy, e.ll, e.lc);
            end
        end
        if (done) begin
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d expectations left, want 0", sb.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] lc;
        reset        = 1'b1;
        pll_lock     = 1'b0;
        sw_reset_req = 1'b0;
        e0           = 0;
        exp_at(2, "reset_state", 3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        repeat (3) @(negedge clk);

        // Power-up: lock rises as reset releases
        reset    = 1'b0;
        pll_lock = 1'b1;
        e0       = cyc + 1;
        exp_at(1,  "pu_e1_wait",    3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        exp_at(2,  "pu_e2_filter",  3'd1, 1'b1, 1'b0, 1'b0, 4'd0);
        exp_at(17, "pu_e17_filter", 3'd1, 1'b1, 1'b0, 1'b0, 4'd0);
        exp_at(18, "pu_e18_hold",   3'd2, 1'b1, 1'b0, 1'b0, 4'd0);
        exp_at(81, "pu_e81_hold",   3'd2, 1'b1, 1'b0, 1'b0, 4'd0);
        exp_at(82, "pu_e82_run",    3'd3, 1'b0, 1'b1, 1'b0, 4'd0);
        wait_to(82);

        // Loss of lock in RUN
        pll_lock = 1'b0;
        e0       = cyc + 1;
        exp_at(1, "loss_e1_run",  3'd3, 1'b0, 1'b1, 1'b0, 4'd0);
        exp_at(2, "loss_e2_pulse", 3'd0, 1'b1, 1'b0, 1'b1, 4'd1);
        exp_at(3, "loss_e3_clear", 3'd0, 1'b1, 1'b0, 1'b0, 4'd1);
        wait_to(3);

        // Lock chatter: 10 cycles high, 1 low, then high again
        pll_lock = 1'b1;
        e0       = cyc + 1;
        exp_at(2,  "chat_filter",  3'd1, 1'b1, 1'b0, 1'b0, 4'd1);
        exp_at(11, "chat_filter2", 3'd1, 1'b1, 1'b0, 1'b0, 4'd1);
        exp_at(12, "chat_restart", 3'd0, 1'b1, 1'b0, 1'b0, 4'd1);
        exp_at(13, "chat_refilter", 3'd1, 1'b1, 1'b0, 1'b0, 4'd1);
        exp_at(92, "chat_hold",    3'd2, 1'b1, 1'b0, 1'b0, 4'd1);
        exp_at(93, "chat_run",     3'd3, 1'b0, 1'b1, 1'b0, 4'd1);
        wait_to(9);
        pll_lock = 1'b0;
        wait_to(10);
        pll_lock = 1'b1;
        wait_to(93);

        // Software reset in RUN
        sw_reset_req = 1'b1;
        e0           = cyc + 1;
        exp_at(0,  "sw_e0_hold",  3'd2, 1'b1, 1'b0, 1'b0, 4'd1);
        exp_at(63, "sw_e63_hold", 3'd2, 1'b1, 1'b0, 1'b0, 4'd1);
        exp_at(64, "sw_e64_run",  3'd3, 1'b0, 1'b1, 1'b0, 4'd1);
        wait_to(0);
        sw_reset_req = 1'b0;
        wait_to(64);

        // Second request arriving while in HOLD must not extend the hold
        sw_reset_req = 1'b1;
        e0           = cyc + 1;
        exp_at(0,  "swh_e0_hold",  3'd2, 1'b1, 1'b0, 1'b0, 4'd1);
        exp_at(10, "swh_e10_hold", 3'd2, 1'b1, 1'b0, 1'b0, 4'd1);
        exp_at(63, "swh_e63_hold", 3'd2, 1'b1, 1'b0, 1'b0, 4'd1);
        exp_at(64, "swh_e64_run",  3'd3, 1'b0, 1'b1, 1'b0, 4'd1);
        wait_to(0);
        sw_reset_req = 1'b0;
        wait_to(9);
        sw_reset_req = 1'b1;
        wait_to(10);
        sw_reset_req = 1'b0;
        wait_to(64);

        // Lock loss and software request seen on the same edge
        pll_lock = 1'b0;
        e0       = cyc + 1;
        exp_at(1, "both_e1_run",   3'd3, 1'b0, 1'b1, 1'b0, 4'd1);
        exp_at(2, "both_e2_wait",  3'd0, 1'b1, 1'b0, 1'b1, 4'd2);
        exp_at(3, "both_e3_clear", 3'd0, 1'b1, 1'b0, 1'b0, 4'd2);
        wait_to(1);
        sw_reset_req = 1'b1;
        wait_to(2);
        sw_reset_req = 1'b0;
        wait_to(3);

        // Saturation of the loss counter
        lc = 4'd2;
        for (int i = 0; i < 17; i++) begin
            pll_lock = 1'b1;
            e0       = cyc + 1;
            exp_at(82, $sformatf("sat_run%0d", i), 3'd3, 1'b0, 1'b1, 1'b0, lc);
            wait_to(82);
            pll_lock = 1'b0;
            e0       = cyc + 1;
            lc       = (lc == 4'd15) ? 4'd15 : lc + 4'd1;
            exp_at(2, $sformatf("sat_loss%0d", i), 3'd0, 1'b1, 1'b0, 1'b1, lc);
            wait_to(3);
        end

        // Block reset asserted mid-HOLD
        pll_lock = 1'b1;
        e0       = cyc + 1;
        exp_at(40, "rst_pre_hold", 3'd2, 1'b1, 1'b0, 1'b0, 4'd15);
        exp_at(41, "rst_applied",  3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        exp_at(42, "rst_released", 3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        wait_to(40);
        reset = 1'b1;
        wait_to(41);
        reset = 1'b0;
        wait_to(43);
        done = 1'b1;
    end

endmodule
